// File: rtl/boot_copy_if.sv
// Boot-copy bus bundle: combinational ROM read port plus RAM write port with
// a ready handshake.
interface boot_copy_if #(
  parameter int unsigned ROM_AW = 9,
  parameter int unsigned RAM_AW = 19
);
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_we;
  logic              ram_ready;

  modport master (
    output rom_addr, ram_addr, ram_dout, ram_we,
    input  rom_data, ram_ready
  );

  modport slave (
    input  rom_addr, ram_addr, ram_dout, ram_we,
    output rom_data, ram_ready
  );
endinterface

// File: rtl/boot_copy_ctrl.sv
// Boot ROM to RAM copy sequencer: keeps the Z80 in reset until the image is
// in RAM and a settle delay has elapsed, then releases it.
module boot_copy_ctrl #(
  parameter int unsigned BOOT_LEN      = 275,
  parameter int unsigned ROM_AW        = 9,
  parameter int unsigned RAM_AW        = 19,
  parameter int unsigned RAM_BASE      = 0,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  boot_copy_if.master bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done
);
  // One extra count bit so BOOT_LEN = 2**ROM_AW never wraps.
  localparam int unsigned CW = ROM_AW + 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(BOOT_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, SETTLE, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [SW-1:0]     settle, settle_n;
  logic              first;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_n;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_n;
  logic [7:0]        ram_dout_q, ram_dout_n;
  logic              ram_we_q, ram_we_n;
  logic              hold_n, busy_n, done_n;

  assign bus.rom_addr = rom_addr_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_we   = ram_we_q;

  // State and output registers; first marks the cycle right after reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      settle     <= '0;
      first      <= 1'b1;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      ram_we_q   <= 1'b0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      settle     <= settle_n;
      first      <= 1'b0;
      rom_addr_q <= rom_addr_n;
      ram_addr_q <= ram_addr_n;
      ram_dout_q <= ram_dout_n;
      ram_we_q   <= ram_we_n;
      cpu_hold   <= hold_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    count_n    = count;
    settle_n   = settle;
    rom_addr_n = rom_addr_q;
    ram_addr_n = ram_addr_q;
    ram_dout_n = ram_dout_q;
    ram_we_n   = ram_we_q;
    hold_n     = cpu_hold;
    busy_n     = busy;
    done_n     = done;
    case (state)
      IDLE: begin
        if ((AUTO_START && first) || start) begin
          state_n    = FETCH;
          count_n    = '0;
          rom_addr_n = '0;
          busy_n     = 1'b1;
          hold_n     = 1'b1;
        end
      end
      FETCH: begin
        ram_dout_n = bus.rom_data;
        ram_addr_n = RAM_AW'(RAM_BASE) + RAM_AW'(count);
        ram_we_n   = 1'b1;
        state_n    = WRITE;
      end
      WRITE: begin
        if (bus.ram_ready) begin
          ram_we_n = 1'b0;
          if (count == LAST) begin
            state_n  = SETTLE;
            settle_n = SW'(SETTLE_CYCLES);
          end else begin
            count_n    = count + CW'(1);
            rom_addr_n = ROM_AW'(count + CW'(1));
            state_n    = FETCH;
          end
        end
      end
      SETTLE: begin
        if (settle == '0) begin
          hold_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          settle_n = settle - SW'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_n    = FETCH;
          count_n    = '0;
          rom_addr_n = '0;
          hold_n     = 1'b1;
          busy_n     = 1'b1;
          done_n     = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Bench for boot_copy_ctrl: three instances (default, single-byte at the top
// of RAM, manual start) share one write monitor fed from an expected queue.
module tb_boot_copy_ctrl;
  localparam int unsigned N = 275;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic rdy = 1'b1;
  logic hold_a, busy_a, done_a, hold_b, busy_b, done_b, hold_c, busy_c, done_c;
  int total = 0;
  int bad = 0;

  boot_copy_if #(.ROM_AW(9), .RAM_AW(19)) ifa ();
  boot_copy_if #(.ROM_AW(9), .RAM_AW(19)) ifb ();
  boot_copy_if #(.ROM_AW(9), .RAM_AW(19)) ifc ();

  // ROM models: ramp for a/c, inverted ramp for b so its single byte is non-zero.
  assign ifa.rom_data  = ifa.rom_addr[7:0];
  assign ifb.rom_data  = ~ifb.rom_addr[7:0];
  assign ifc.rom_data  = ifc.rom_addr[7:0];
  assign ifa.ram_ready = rdy;
  assign ifb.ram_ready = rdy;
  assign ifc.ram_ready = rdy;

  boot_copy_ctrl dut_a (
    .clk_sys(clk), .reset(rst_a), .start(start_a), .bus(ifa),
    .cpu_hold(hold_a), .busy(busy_a), .done(done_a));

  boot_copy_ctrl #(.BOOT_LEN(1), .SETTLE_CYCLES(0), .RAM_BASE(32'h7FFFF)) dut_b (
    .clk_sys(clk), .reset(rst_b), .start(start_b), .bus(ifb),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b));

  boot_copy_ctrl #(.AUTO_START(1'b0)) dut_c (
    .clk_sys(clk), .reset(rst_c), .start(start_c), .bus(ifc),
    .cpu_hold(hold_c), .busy(busy_c), .done(done_c));

  // Write monitor: sel picks the instance under test.
  logic [1:0]  sel = 2'd0;
  bit          mon_en = 1'b0;
  logic [26:0] q[$];
  logic        mon_we;
  logic [26:0] mon_wr;

  always_comb begin
    mon_we = ifa.ram_we;
    mon_wr = {ifa.ram_addr, ifa.ram_dout};
    if (sel == 2'd1) begin
      mon_we = ifb.ram_we;
      mon_wr = {ifb.ram_addr, ifb.ram_dout};
    end else if (sel == 2'd2) begin
      mon_we = ifc.ram_we;
      mon_wr = {ifc.ram_addr, ifc.ram_dout};
    end
  end

  bit          stall = 1'b0, acc = 1'b0;
  logic [26:0] last_wr, exp_wr;

  always @(negedge clk) begin
    if (!mon_en) begin
      stall = 1'b0;
      acc   = 1'b0;
    end else begin
      if (stall) begin
        total++;
        if (mon_we !== 1'b1 || mon_wr !== last_wr) begin
          bad++;
          $display("FAIL hold_stable: we=%b wr=%h, required we=1 wr=%h", mon_we, mon_wr, last_wr);
        end
      end
      if (acc) begin
        total++;
        if (mon_we !== 1'b0) begin
          bad++;
          $display("FAIL we_pulse: we=%b after accept, required 0", mon_we);
        end
      end
      acc     = mon_we && rdy;
      stall   = mon_we && !rdy;
      last_wr = mon_wr;
      if (acc) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_write: wr=%h, required no write", mon_wr);
        end else begin
          exp_wr = q.pop_front();
          if (mon_wr !== exp_wr) begin
            bad++;
            $display("FAIL write_seq: addr/data=%h, required %h", mon_wr, exp_wr);
          end
        end
      end
    end
  end

  task automatic push_ramp();
    q.delete();
    for (int i = 0; i < int'(N); i++) q.push_back({19'(i), 8'(i)});
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ifa.rom_addr, ifa.ram_addr, ifa.ram_dout, ifa.ram_we} !== 37'd0) begin
      bad++;
      $display("FAIL reset_bus_a: %h, required 0",
               {ifa.rom_addr, ifa.ram_addr, ifa.ram_dout, ifa.ram_we});
    end
    total++;
    if ({hold_a, busy_a, done_a} !== 3'b100) begin
      bad++;
      $display("FAIL reset_status_a: %b, required 100", {hold_a, busy_a, done_a});
    end
    total++;
    if ({hold_b, busy_b, done_b, ifb.ram_we} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_status_b: %b, required 1000", {hold_b, busy_b, done_b, ifb.ram_we});
    end
    rst_c = 1'b0;
  endtask

  task automatic test_auto_copy();
    int t = -1;
    bit early = 1'b0;
    push_ramp();
    sel = 2'd0; rdy = 1'b1; mon_en = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    // Edge 0 is the IDLE cycle that launches the copy.
    for (int i = 0; i < 2000 && t < 0; i++) begin
      @(posedge clk);
      #1;
      if (done_a) t = i;
      else if (!hold_a) early = 1'b1;
    end
    total++;
    if (t !== 2 * int'(N) + 16 + 1) begin
      bad++;
      $display("FAIL release_cycle: done at edge %0d, required %0d", t, 2 * N + 17);
    end
    total++;
    if (hold_a !== 1'b0 || busy_a !== 1'b0 || early) begin
      bad++;
      $display("FAIL hold_release: hold=%b busy=%b early=%b, required 0 0 0", hold_a, busy_a, early);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes_auto: %0d left, required 0", q.size());
    end
  endtask

  task automatic test_restart();
    push_ramp();
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    total++;
    if ({hold_a, done_a, busy_a} !== 3'b101) begin
      bad++;
      $display("FAIL restart_edge: hold/done/busy=%b, required 101", {hold_a, done_a, busy_a});
    end
    repeat (60) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int i = 0; i < 2000 && !done_a; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if ({done_a, busy_a, hold_a} !== 3'b100) begin
      bad++;
      $display("FAIL restart_done: done/busy/hold=%b, required 100", {done_a, busy_a, hold_a});
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes_restart: %0d left, required 0", q.size());
    end
  endtask

  task automatic test_random_ready();
    push_ramp();
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int i = 0; i < 20000 && !done_a; i++) begin
      rdy = ($urandom_range(0, 9) < 3);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    total++;
    if (done_a !== 1'b1 || hold_a !== 1'b0) begin
      bad++;
      $display("FAIL random_done: done=%b hold=%b, required 1 0", done_a, hold_a);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes_random: %0d left, required 0", q.size());
    end
  endtask

  task automatic test_reset_abort();
    bit found = 1'b0;
    push_ramp();
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ifa.ram_we && ifa.ram_addr == 19'd100) found = 1'b1;
    end
    mon_en = 1'b0;
    rst_a  = 1'b1;
    #1;
    total++;
    if (!found || {ifa.rom_addr, ifa.ram_addr, ifa.ram_dout, ifa.ram_we} !== 37'd0) begin
      bad++;
      $display("FAIL abort_bus: found=%b bus=%h, required 1 and 0", found,
               {ifa.rom_addr, ifa.ram_addr, ifa.ram_dout, ifa.ram_we});
    end
    total++;
    if ({hold_a, busy_a, done_a} !== 3'b100) begin
      bad++;
      $display("FAIL abort_status: %b, required 100", {hold_a, busy_a, done_a});
    end
    // Release with start coincident: still only one copy.
    push_ramp();
    repeat (2) @(posedge clk);
    #1;
    mon_en  = 1'b1;
    rst_a   = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int i = 0; i < 2000 && !done_a; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if ({done_a, busy_a, hold_a} !== 3'b100 || q.size() != 0) begin
      bad++;
      $display("FAIL abort_recopy: done/busy/hold=%b left=%0d, required 100 and 0",
               {done_a, busy_a, hold_a}, q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_single_byte();
    bit found = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    q.push_back({19'h7FFFF, 8'hFF});
    sel = 2'd1; rdy = 1'b0; mon_en = 1'b1;
    rst_b = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ifb.ram_we) found = 1'b1;
    end
    total++;
    if (!found || ifb.ram_addr !== 19'h7FFFF) begin
      bad++;
      $display("FAIL single_addr: found=%b addr=%h, required 1 7ffff", found, ifb.ram_addr);
    end
    repeat (2) @(posedge clk);
    #1 rdy = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({hold_b, done_b, ifb.ram_we} !== 3'b100) begin
      bad++;
      $display("FAIL single_settle: hold/done/we=%b, required 100", {hold_b, done_b, ifb.ram_we});
    end
    @(posedge clk);
    #1;
    total++;
    if ({hold_b, done_b, busy_b} !== 3'b010 || q.size() != 0) begin
      bad++;
      $display("FAIL single_release: hold/done/busy=%b left=%0d, required 010 and 0",
               {hold_b, done_b, busy_b}, q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_manual_start();
    bit seen = 1'b0;
    sel = 2'd2; rdy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (ifc.ram_we !== 1'b0 || hold_c !== 1'b1 || busy_c !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL manual_idle: activity=%b without start, required 0", seen);
    end
    push_ramp();
    mon_en  = 1'b1;
    start_c = 1'b1;
    @(posedge clk);
    #1 start_c = 1'b0;
    total++;
    if ({busy_c, hold_c} !== 2'b11) begin
      bad++;
      $display("FAIL manual_start: busy/hold=%b, required 11", {busy_c, hold_c});
    end
    for (int i = 0; i < 2000 && !done_c; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({done_c, hold_c} !== 2'b10 || q.size() != 0) begin
      bad++;
      $display("FAIL manual_done: done/hold=%b left=%0d, required 10 and 0",
               {done_c, hold_c}, q.size());
    end
    mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_copy();
    test_restart();
    test_random_ready();
    test_reset_abort();
    test_single_byte();
    test_manual_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
